// File: rtl/score_pkg.sv
// Shared definitions for the score tracker: FSM encoding, BCD sizing and the
// shift-add-3 digit correction used by the iterative converter.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAYING  = 2'd1,
    ST_FINISHED = 2'd2
  } state_t;

  localparam int         BCD_DIGITS  = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Any digit at 5 or above gets +3 so the following left shift carries into the next digit.
  function automatic logic [4*BCD_DIGITS-1:0] bcd_add3(input logic [4*BCD_DIGITS-1:0] v);
    logic [4*BCD_DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] >= ADD3_THRESH) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3), one bit per cycle.
// A start while busy aborts the current conversion and reloads; bcd holds the last finished result.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int W = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [W-1:0]            bin,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]            r_bin;
  logic [4*BCD_DIGITS-1:0] r_work;
  logic [4*BCD_DIGITS-1:0] r_bcd;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic [4*BCD_DIGITS-1:0] w_adj;
  logic [4*BCD_DIGITS-1:0] w_shift;

  assign w_adj   = bcd_add3(r_work);
  assign w_shift = {w_adj[4*BCD_DIGITS-2:0], r_bin[W-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin  <= '0;
      r_work <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bin  <= bin;
        r_work <= '0;
        r_cnt  <= CNT_W'(W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_work <= w_shift;
        r_bin  <= r_bin << 1;
        r_cnt  <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_bcd  <= w_shift;
        end
      end
    end
  end

  assign bcd  = r_bcd;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: rtl/score_tracker.sv
// Game FSM, score/streak/best counters and BCD restart control for the whack-a-mole score path.
// Optional build macro MISS_PENALTY_EN: a miss while playing also takes one point (floored at 0).
module score_tracker
  import score_pkg::*;
#(
  parameter int SCORE_W      = 12,
  parameter int STREAK_W     = 8,
  parameter int BONUS_THRESH = 5,
  parameter int BONUS_PTS    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                game_start,
  input  logic                hit,
  input  logic                miss,
  input  logic                gameover,
  output logic [SCORE_W-1:0]  score,
  output logic [STREAK_W-1:0] streak,
  output logic [SCORE_W-1:0]  best_score,
  output logic                new_best,
  output logic [15:0]         score_bcd,
  output logic                bcd_valid
);

  // Four BCD digits only cover up to 9999.
  if (SCORE_W > 13) begin : g_width_chk
    $error("score_tracker: SCORE_W must be <= 13");
  end

  state_t              r_state;
  logic [SCORE_W-1:0]  r_score;
  logic [STREAK_W-1:0] r_streak;
  logic [SCORE_W-1:0]  r_best;
  logic                r_new_best;
  logic                r_cmp;
  logic                r_start;
  logic                r_bcd_valid;

  logic [SCORE_W:0]    w_sum;
  logic [SCORE_W-1:0]  w_score_hit;
  logic [SCORE_W-1:0]  w_score_nxt;
  logic [STREAK_W-1:0] w_streak_nxt;
  logic                w_busy;
  logic                w_done;

  // Bonus is judged on the streak before this hit counts.
  assign w_sum       = {1'b0, r_score} + ((r_streak >= STREAK_W'(BONUS_THRESH))
                                          ? (SCORE_W+1)'(BONUS_PTS) : (SCORE_W+1)'(1));
  assign w_score_hit = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

  always_comb begin
    w_score_nxt  = r_score;
    w_streak_nxt = r_streak;
    if (game_start) begin
      w_score_nxt  = '0;
      w_streak_nxt = '0;
    end else if (r_state == ST_PLAYING) begin
      if (hit) begin
        w_score_nxt  = w_score_hit;
        w_streak_nxt = (r_streak == '1) ? r_streak : r_streak + STREAK_W'(1);
      end else if (miss) begin
        w_streak_nxt = '0;
`ifdef MISS_PENALTY_EN
        if (r_score != '0) w_score_nxt = r_score - SCORE_W'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_score     <= '0;
      r_streak    <= '0;
      r_best      <= '0;
      r_new_best  <= 1'b0;
      r_cmp       <= 1'b0;
      r_start     <= 1'b0;
      r_bcd_valid <= 1'b1;
    end else begin
      r_new_best <= 1'b0;
      r_cmp      <= 1'b0;
      r_start    <= 1'b0;
      r_score    <= w_score_nxt;
      r_streak   <= w_streak_nxt;

      if (game_start) r_state <= ST_PLAYING;
      else if (r_state == ST_PLAYING && gameover) begin
        r_state <= ST_FINISHED;
        r_cmp   <= 1'b1;
      end

      // Compare one cycle after the transition so a same-cycle hit is already in r_score.
      if (r_cmp && (r_score > r_best)) begin
        r_best     <= r_score;
        r_new_best <= 1'b1;
      end

      // A done from a superseded conversion must not raise valid while a restart is pending.
      if (w_score_nxt != r_score) begin
        r_start     <= 1'b1;
        r_bcd_valid <= 1'b0;
      end else if (w_done && !r_start && !w_busy) begin
        r_bcd_valid <= 1'b1;
      end
    end
  end

  bin2bcd_seq #(.W(SCORE_W)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (r_start),
    .bin   (r_score),
    .bcd   (score_bcd),
    .busy  (w_busy),
    .done  (w_done)
  );

  assign score      = r_score;
  assign streak     = r_streak;
  assign best_score = r_best;
  assign new_best   = r_new_best;
  assign bcd_valid  = r_bcd_valid;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: reset, scoring/bonus, miss handling, best score, saturation, BCD restart.
module tb_score_tracker;

  localparam int SW = 12;
  localparam int KW = 8;
`ifdef MISS_PENALTY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, game_start, hit, miss, gameover;
  logic [SW-1:0] score, best_score;
  logic [KW-1:0] streak;
  logic          new_best;
  logic [15:0]   score_bcd;
  logic          bcd_valid;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  score_tracker #(.SCORE_W(SW), .STREAK_W(KW), .BONUS_THRESH(5), .BONUS_PTS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .game_start (game_start),
    .hit        (hit),
    .miss       (miss),
    .gameover   (gameover),
    .score      (score),
    .streak     (streak),
    .best_score (best_score),
    .new_best   (new_best),
    .score_bcd  (score_bcd),
    .bcd_valid  (bcd_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic pulse_start();
    game_start = 1'b1; tick(); game_start = 1'b0;
  endtask

  task automatic do_hit();
    hit = 1'b1; tick(); hit = 1'b0;
  endtask

  task automatic do_miss();
    miss = 1'b1; tick(); miss = 1'b0;
  endtask

  task automatic run(input int n);
    hit = 1'b1;
    repeat (n) tick();
    hit = 1'b0;
  endtask

  task automatic end_game();
    gameover = 1'b1; tick(); gameover = 1'b0;
  endtask

  // Latency bound is counted from the edge that changed the score.
  task automatic wait_valid(input string tag, input logic [15:0] exp_bcd);
    int n;
    n = 0;
    while (!bcd_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(bcd_valid), 32'd1);
    check({tag, "_latency_le14"}, 32'(n <= 14), 32'd1);
    check({tag, "_bcd"}, 32'(score_bcd), 32'(exp_bcd));
  endtask

  initial begin
    int vhigh;
    reset = 1'b1; game_start = 1'b0; hit = 1'b0; miss = 1'b0; gameover = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_score",    32'(score), 0);
    check("rst_streak",   32'(streak), 0);
    check("rst_best",     32'(best_score), 0);
    check("rst_new_best", 32'(new_best), 0);
    check("rst_bcd",      32'(score_bcd), 0);
    check("rst_valid",    32'(bcd_valid), 1);
    do_hit();
    check("idle_hit_ignored", 32'(score), 0);

    // 1: three hits
    pulse_start();
    do_hit(); do_hit(); do_hit();
    check("t1_score",  32'(score), 3);
    check("t1_streak", 32'(streak), 3);
    check("t1_valid_drop", 32'(bcd_valid), 0);
    wait_valid("t1", 16'h0003);

    // 2: seven consecutive hits, bonus from the sixth
    pulse_start();
    check("t2_restart_score", 32'(score), 0);
    run(7);
    check("t2_score",  32'(score), 9);
    check("t2_streak", 32'(streak), 7);
    wait_valid("t2", 16'h0009);

    // 3: hit wins over miss; lone miss; miss at zero
    pulse_start();
    run(4);
    check("t3_pre_score", 32'(score), 4);
    hit = 1'b1; miss = 1'b1; tick(); hit = 1'b0; miss = 1'b0;
    check("t3_hm_score",  32'(score), 5);
    check("t3_hm_streak", 32'(streak), 5);
    do_miss();
    check("t3_miss_streak", 32'(streak), 0);
    check("t3_miss_score",  32'(score), 5 - PEN);
    pulse_start();
    do_miss();
    check("t3_miss_zero_score", 32'(score), 0);

    // 4: best score across three games
    pulse_start();
    run(6); do_miss(); run(5);
    check("t4_g1_score", 32'(score), 12 - PEN);
    end_game();
    check("t4_g1_nb_early", 32'(new_best), 0);
    tick();
    check("t4_g1_nb",   32'(new_best), 1);
    check("t4_g1_best", 32'(best_score), 12 - PEN);
    tick();
    check("t4_g1_nb_1cyc", 32'(new_best), 0);
    do_hit();
    check("t4_finished_hit_ignored", 32'(score), 12 - PEN);

    pulse_start();
    run(6); do_miss(); run(5);
    end_game();
    tick();
    check("t4_g2_nb_equal", 32'(new_best), 0);
    tick();
    check("t4_g2_nb_after", 32'(new_best), 0);
    check("t4_g2_best",     32'(best_score), 12 - PEN);

    pulse_start();
    check("t4_g3_best_kept", 32'(best_score), 12 - PEN);
    check("t4_g3_score_clr", 32'(score), 0);
    run(6); do_miss(); run(8);
    hit = 1'b1; gameover = 1'b1; tick(); hit = 1'b0; gameover = 1'b0;
    check("t4_g3_score", 32'(score), 20 - PEN);
    tick();
    check("t4_g3_nb",   32'(new_best), 1);
    check("t4_g3_best", 32'(best_score), 20 - PEN);

    // 5: saturation at 4095
    pulse_start();
    run(1 + PEN); do_miss();
    check("t5_base", 32'(score), 1);
    run(2049);
    check("t5_4094",   32'(score), 4094);
    check("t5_streak", 32'(streak), 255);
    run(3);
    check("t5_sat", 32'(score), 4095);
    wait_valid("t5", 16'h4095);

    // 6: hits 3 cycles apart keep restarting the converter
    pulse_start();
    wait_valid("t6_zero", 16'h0000);
    vhigh = 0;
    for (int i = 0; i < 4; i++) begin
      do_hit();
      if (bcd_valid) vhigh++;
      repeat (2) begin
        tick();
        if (bcd_valid) vhigh++;
      end
    end
    check("t6_valid_stays_low", 32'(vhigh), 0);
    check("t6_bcd_held", 32'(score_bcd), 16'h0000);
    wait_valid("t6", 16'h0004);

    // mid-game reset
    run(3);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mr_score",    32'(score), 0);
    check("mr_streak",   32'(streak), 0);
    check("mr_best",     32'(best_score), 0);
    check("mr_new_best", 32'(new_best), 0);
    check("mr_bcd",      32'(score_bcd), 0);
    check("mr_valid",    32'(bcd_valid), 1);
    do_hit();
    check("mr_idle_hit", 32'(score), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
